// File: rtl/credit_hit_tracker.sv
// credit_hit_tracker
//
// Turns the raw per-pixel ball/credit overlap strobe into one debounced hit
// per ball contact. Overlaps are collected per credit during a frame and
// judged at the next startOfFrame. A credit scores only when it is armed
// (cooldown == 0). Any contact reloads its cooldown, so a ball resting on a
// credit scores once. Scored hits are queued in a pending mask and sent to
// the score logic one per cycle, lowest index first.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   startOfFrame  one-cycle pulse on the first pixel of a frame
//   drawBall      ball covers the current pixel
//   drawCredit    a credit circle covers the current pixel
//   hitIndex      credit under the current pixel (valid with drawCredit)
//   readIndex     credit whose count the display wants
//   number        registered count of credit readIndex (0 if out of range)
//   scorePulse    one-cycle pulse per scored hit
//   scoreIndex    credit index of the current pulse, held between pulses
//   armedMask     bit i set while credit i has no cooldown running
module credit_hit_tracker #(
    parameter int NUM_CREDITS     = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MAX_VALUE       = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   drawBall,
    input  logic                   drawCredit,
    input  logic [3:0]             hitIndex,
    input  logic [3:0]             readIndex,
    output logic [3:0]             number,
    output logic                   scorePulse,
    output logic [3:0]             scoreIndex,
    output logic [NUM_CREDITS-1:0] armedMask
);

    localparam logic [7:0] COOL = 8'(COOLDOWN_FRAMES);
    localparam logic [3:0] MAXV = 4'(MAX_VALUE);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t                 state_q, state_d;
    logic [NUM_CREDITS-1:0] touched_q, touched_d;
    logic [NUM_CREDITS-1:0] pending_q, pending_d;
    logic [NUM_CREDITS-1:0] hit_mask;
    logic [NUM_CREDITS-1:0] emit_mask;
    logic [7:0]             cooldown_q [NUM_CREDITS];
    logic [7:0]             cooldown_d [NUM_CREDITS];
    logic [3:0]             value_q    [NUM_CREDITS];
    logic [3:0]             value_d    [NUM_CREDITS];
    logic [3:0]             number_q, number_d;
    logic [3:0]             index_hold_q, index_hold_d;
    logic [3:0]             emit_index;
    logic                   overlap;

    assign overlap = drawBall && drawCredit;

    // Per-credit frame evaluation and overlap accumulation. The clear of the
    // frame-local flag comes before the set so that an overlap on the
    // startOfFrame pixel belongs to the new frame.
    always_comb begin
        touched_d = touched_q;
        hit_mask  = '0;
        for (int i = 0; i < NUM_CREDITS; i++) begin
            cooldown_d[i] = cooldown_q[i];
            value_d[i]    = value_q[i];
            if (startOfFrame) begin
                if (touched_q[i]) begin
                    // Any contact re-blocks the credit; only an armed one scores.
                    cooldown_d[i] = COOL;
                    if (cooldown_q[i] == 8'd0) begin
                        hit_mask[i] = 1'b1;
                        if (value_q[i] != MAXV) begin
                            value_d[i] = value_q[i] + 4'd1;
                        end
                    end
                end else if (cooldown_q[i] != 8'd0) begin
                    cooldown_d[i] = cooldown_q[i] - 8'd1;
                end
                touched_d[i] = 1'b0;
            end
            // Indices at or above NUM_CREDITS never match and are ignored.
            if (overlap && (hitIndex == 4'(i))) begin
                touched_d[i] = 1'b1;
            end
        end
    end

    // Score serializer: while in EMIT the lowest pending credit is presented
    // on the outputs and retired at the next edge. New hits are merged in the
    // same cycle, so a busy serializer never loses a request.
    always_comb begin
        state_d      = state_q;
        emit_index   = 4'd0;
        emit_mask    = '0;
        index_hold_d = index_hold_q;
        for (int i = NUM_CREDITS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                emit_index = 4'(i);
            end
        end
        for (int i = 0; i < NUM_CREDITS; i++) begin
            emit_mask[i] = (state_q == S_EMIT) && (emit_index == 4'(i));
        end
        pending_d = (pending_q & ~emit_mask) | hit_mask;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                index_hold_d = emit_index;
                if (pending_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Readout mux; out-of-range indices read as zero.
    always_comb begin
        number_d = 4'd0;
        for (int i = 0; i < NUM_CREDITS; i++) begin
            if (readIndex == 4'(i)) begin
                number_d = value_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            touched_q    <= '0;
            pending_q    <= '0;
            number_q     <= 4'd0;
            index_hold_q <= 4'd0;
            for (int i = 0; i < NUM_CREDITS; i++) begin
                cooldown_q[i] <= 8'd0;
                value_q[i]    <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            touched_q    <= touched_d;
            pending_q    <= pending_d;
            number_q     <= number_d;
            index_hold_q <= index_hold_d;
            for (int i = 0; i < NUM_CREDITS; i++) begin
                cooldown_q[i] <= cooldown_d[i];
                value_q[i]    <= value_d[i];
            end
        end
    end

    // EMIT is only ever entered with a non-empty pending mask, so the state
    // alone marks a valid pulse.
    assign scorePulse = (state_q == S_EMIT);
    assign scoreIndex = scorePulse ? emit_index : index_hold_q;
    assign number     = number_q;

    for (genvar gi = 0; gi < NUM_CREDITS; gi++) begin : g_armed
        assign armedMask[gi] = (cooldown_q[gi] == 8'd0);
    end

endmodule

// File: tb/tb_credit_hit_tracker.sv
module tb_credit_hit_tracker;
    localparam int NC   = 4;
    localparam int COOL = 8;
    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sof = 1'b0, ball = 1'b0, cred = 1'b0;
    logic [3:0] hit = 4'd0, rd = 4'd0;
    logic [3:0] number, score_index;
    logic       score_pulse;
    logic [NC-1:0] armed;

    credit_hit_tracker #(.NUM_CREDITS(NC), .COOLDOWN_FRAMES(COOL), .MAX_VALUE(MAXV)) dut (
        .clk(clk), .reset(rst), .startOfFrame(sof), .drawBall(ball), .drawCredit(cred),
        .hitIndex(hit), .readIndex(rd), .number(number), .scorePulse(score_pulse),
        .scoreIndex(score_index), .armedMask(armed));

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int pulses_seen = 0;

    // Reference model: frame-level bookkeeping plus a queue of expected pulses.
    bit m_t[NC];
    int m_cd[NC], m_val[NC];
    int m_num = 0, m_last = 0;
    int q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        int num_next;
        int exp_idx;
        logic [NC-1:0] exp_armed;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NC; i++) begin m_t[i] = 0; m_cd[i] = 0; m_val[i] = 0; end
            q.delete();
            m_num = 0; m_last = 0;
        end else begin
            num_next = (rd < NC) ? m_val[rd] : 0;
            if (sof) begin
                for (int i = 0; i < NC; i++) begin
                    if (m_t[i]) begin
                        if (m_cd[i] == 0) begin
                            if (m_val[i] < MAXV) m_val[i]++;
                            q.push_back(i);
                        end
                        m_cd[i] = COOL;
                    end else if (m_cd[i] > 0) begin
                        m_cd[i]--;
                    end
                    m_t[i] = 0;
                end
            end
            if (ball && cred && hit < NC) m_t[hit] = 1;
            m_num = num_next;
        end
        #1;
        for (int i = 0; i < NC; i++) exp_armed[i] = (m_cd[i] == 0);
        check("number", number, m_num);
        check("armed", armed, exp_armed);
        if (score_pulse) pulses_seen++;
        if (q.size() == 0) begin
            check("no_pulse", score_pulse, 0);
            check("idx_hold", score_index, m_last);
        end else if (score_pulse) begin
            exp_idx = q.pop_front();
            check("pulse_idx", score_index, exp_idx);
            m_last = exp_idx;
        end else begin
            check("idx_hold", score_index, m_last);
        end
    endtask

    task automatic touch(input logic [3:0] idx);
        ball = 1; cred = 1; hit = idx;
        tick();
        ball = 0; cred = 0; hit = 0;
    endtask

    task automatic sof_tick();
        check("drained_before_sof", q.size(), 0);
        sof = 1;
        tick();
        sof = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    typedef struct {
        logic [3:0] mask;
        bit         bad;
        logic [3:0] rdi;
        int         exp_num;
        int         exp_pulses;
        logic [3:0] exp_armed;
    } step_t;
    step_t tbl[7];

    initial begin
        tbl[0] = '{4'b0100, 1'b0, 4'd2, 1, 1, 4'b1011};
        tbl[1] = '{4'b0000, 1'b0, 4'd2, 1, 0, 4'b1011};
        tbl[2] = '{4'b1011, 1'b1, 4'd3, 1, 3, 4'b0000};
        tbl[3] = '{4'b0100, 1'b0, 4'd2, 1, 0, 4'b0000};
        tbl[4] = '{4'b0000, 1'b1, 4'd15, 0, 0, 4'b0000};
        tbl[5] = '{4'b0001, 1'b0, 4'd0, 1, 0, 4'b0000};
        tbl[6] = '{4'b0000, 1'b0, 4'd1, 1, 0, 4'b0000};

        do_reset();
        check("reset_armed", armed, 4'hF);
        check("reset_number", number, 0);
        check("reset_pulse", score_pulse, 0);

        // Table-driven frames: touches, then the evaluating startOfFrame.
        foreach (tbl[s]) begin
            for (int i = 0; i < NC; i++)
                if (tbl[s].mask[i]) begin touch(4'(i)); touch(4'(i)); end
            if (tbl[s].bad) touch(4'd15);
            rd = tbl[s].rdi;
            pulses_seen = 0;
            sof_tick();
            idle(8);
            check("tbl_number", number, tbl[s].exp_num);
            check("tbl_pulses", pulses_seen, tbl[s].exp_pulses);
            check("tbl_armed", armed, tbl[s].exp_armed);
        end

        // Pulse latency and reset during the second of three pulses.
        do_reset();
        touch(4'd0); touch(4'd1); touch(4'd2);
        sof_tick();
        check("lat_no_pulse_yet", score_pulse, 0);
        tick();
        check("first_pulse", score_pulse, 1);
        check("first_idx", score_index, 0);
        tick();
        check("second_pulse", score_pulse, 1);
        check("second_idx", score_index, 1);
        rst = 1;
        tick();
        rst = 0;
        check("rst_pulse", score_pulse, 0);
        check("rst_idx", score_index, 0);
        check("rst_number", number, 0);
        check("rst_armed", armed, 4'hF);
        pulses_seen = 0;
        idle(5);
        check("rst_no_more_pulses", pulses_seen, 0);
        for (int i = 0; i < NC; i++) begin
            rd = 4'(i); tick(); tick();
            check("rst_value", number, 0);
        end

        // Overlap only on the startOfFrame cycle counts for the new frame.
        rd = 1; pulses_seen = 0;
        sof = 1; ball = 1; cred = 1; hit = 1;
        tick();
        sof = 0; ball = 0; cred = 0; hit = 0;
        idle(8);
        check("bnd_not_yet", pulses_seen, 0);
        check("bnd_num0", number, 0);
        sof_tick();
        idle(8);
        check("bnd_scored", pulses_seen, 1);
        check("bnd_num1", number, 1);

        // Sustained contact on credit 1 for 21 frames.
        do_reset();
        rd = 1; pulses_seen = 0;
        repeat (21) begin touch(4'd1); idle(3); sof_tick(); end
        idle(3);
        check("sus_pulses", pulses_seen, 1);
        check("sus_num", number, 1);
        repeat (7) begin idle(3); sof_tick(); end
        check("sus_still_cooling", armed[1], 0);
        idle(3); sof_tick();
        check("sus_rearmed", armed[1], 1);
        touch(4'd1); sof_tick(); idle(4);
        check("sus_second_hit", number, 2);
        check("sus_pulses2", pulses_seen, 2);

        // Saturation: ten re-armed hits on credit 0.
        do_reset();
        rd = 0; pulses_seen = 0;
        repeat (10) begin
            touch(4'd0); sof_tick();
            repeat (9) begin idle(3); sof_tick(); end
        end
        idle(3);
        check("sat_pulses", pulses_seen, 10);
        check("sat_value", number, MAXV);

        // Randomized frames against the model.
        do_reset();
        for (int f = 0; f < 150; f++) begin
            int len;
            len = $urandom_range(6, 20);
            for (int c = 0; c < len; c++) begin
                int h;
                h = $urandom_range(0, 5);
                ball = ($urandom_range(0, 2) == 0);
                cred = ($urandom_range(0, 1) == 0);
                hit  = (h == 5) ? 4'd15 : 4'(h);
                rd   = 4'($urandom_range(0, 5));
                if (c == 0) sof_tick(); else tick();
            end
        end
        ball = 0; cred = 0;
        idle(8);
        check("final_drain", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
